// File: rtl/if_fetch_bht.sv
// Instruction-fetch stage with a 2-bit saturating-counter branch predictor.
// Drives the IMEM address, captures the word into IF/ID and picks the next PC.
module if_fetch_bht #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        ex_update_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_target_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_pred_o
);

    localparam int         IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic [31:0]      r_pc;
    logic             r_valid;
    logic [31:0]      r_if_pc;
    logic [31:0]      r_if_instr;
    logic             r_if_pred;
    logic [1:0]       r_cnt [BHT_ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_is_br;
    logic             w_pred;
    logic [31:0]      w_imm_b;
    logic [31:0]      w_npc;
    logic [1:0]       w_upd_cnt;
    logic             w_unused;

    assign w_idx     = r_pc[IDX_W+1:2];
    assign w_upd_idx = ex_pc_i[IDX_W+1:2];
    assign w_is_br   = (instr_i[6:0] == OP_BR);
    assign w_imm_b   = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_pred    = w_is_br & r_cnt[w_idx][1];
    assign w_npc     = w_pred ? (r_pc + w_imm_b) : (r_pc + 32'd4);
    assign w_unused  = ^{ex_pc_i[31:IDX_W+2], ex_pc_i[1:0]};

    // Saturating step toward the resolved outcome
    always_comb begin
        w_upd_cnt = r_cnt[w_upd_idx];
        if (ex_taken_i && r_cnt[w_upd_idx] != 2'b11)
            w_upd_cnt = r_cnt[w_upd_idx] + 2'b01;
        else if (!ex_taken_i && r_cnt[w_upd_idx] != 2'b00)
            w_upd_cnt = r_cnt[w_upd_idx] - 2'b01;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                r_cnt[i] <= 2'b01;
        end else if (ex_update_i) begin
            r_cnt[w_upd_idx] <= w_upd_cnt;
        end
    end

    // Redirect beats stall; the word fetched this cycle is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_if_pc    <= 32'h0;
            r_if_instr <= 32'h0;
            r_if_pred  <= 1'b0;
        end else if (ex_redirect_i) begin
            r_pc    <= ex_target_i;
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            r_pc       <= w_npc;
            r_valid    <= 1'b1;
            r_if_pc    <= r_pc;
            r_if_instr <= instr_i;
            r_if_pred  <= w_pred;
        end
    end

    assign pc_o       = r_pc;
    assign if_valid_o = r_valid;
    assign if_pc_o    = r_if_pc;
    assign if_instr_o = r_if_instr;
    assign if_pred_o  = r_if_pred;

endmodule

// File: tb/tb_if_fetch_bht.sv
// Bench for if_fetch_bht: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural fetch/predictor model.
module tb_if_fetch_bht;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        stall_i = 1'b0;
    logic        ex_update_i = 1'b0;
    logic [31:0] ex_pc_i = 32'h0;
    logic        ex_taken_i = 1'b0;
    logic        ex_redirect_i = 1'b0;
    logic [31:0] ex_target_i = 32'h0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_pred_o;

    if_fetch_bht dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .stall_i       (stall_i),
        .ex_update_i   (ex_update_i),
        .ex_pc_i       (ex_pc_i),
        .ex_taken_i    (ex_taken_i),
        .ex_redirect_i (ex_redirect_i),
        .ex_target_i   (ex_target_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_pred_o     (if_pred_o)
    );

    always #5 clk_i = ~clk_i;

    // 16-word memory, address wraps on bits [5:2]
    logic [31:0] mem_w   [16];
    bit          mem_br  [16];
    int          mem_off [16];

    assign instr_i = mem_w[pc_o[5:2]];

    int n_chk  = 0;
    int n_pass = 0;

    // Model state
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_ins;
    logic        m_pred;
    int          m_cnt [16];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] enc_br(input int off);
        logic [12:0] v;
        v = off[12:0];
        return {v[12], v[10:5], 5'd2, 5'd1, 3'b001, v[4:1], v[11], 7'b1100011};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_ins = 32'h0; m_pred = 1'b0;
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_o,       m_pc);
        chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, m_v});
        chk({tag, ".ifpc"},  if_pc_o,    m_ipc);
        chk({tag, ".instr"}, if_instr_o, m_ins);
        chk({tag, ".pred"},  {31'd0, if_pred_o},  {31'd0, m_pred});
    endtask

    // One clock: predict from current model state, advance, compare
    task automatic step(input string tag);
        int          a;
        bit          pred;
        logic [31:0] npc;
        a    = int'(m_pc[5:2]);
        pred = mem_br[a] && (m_cnt[a] >= 2);
        npc  = pred ? m_pc + 32'(mem_off[a]) : m_pc + 32'd4;
        @(posedge clk_i);
        #1;
        if (ex_update_i) begin
            int u;
            u = int'(ex_pc_i[5:2]);
            if (ex_taken_i) m_cnt[u] = (m_cnt[u] == 3) ? 3 : m_cnt[u] + 1;
            else            m_cnt[u] = (m_cnt[u] == 0) ? 0 : m_cnt[u] - 1;
        end
        if (ex_redirect_i) begin
            m_pc = ex_target_i;
            m_v  = 1'b0;
        end else if (!stall_i) begin
            m_v    = 1'b1;
            m_ipc  = m_pc;
            m_ins  = mem_w[a];
            m_pred = pred;
            m_pc   = npc;
        end
        check_all(tag);
        @(negedge clk_i);
    endtask

    task automatic idle();
        stall_i = 0; ex_update_i = 0; ex_redirect_i = 0;
    endtask

    initial begin
        mem_w[0] = 32'h01400093; mem_br[0] = 0; mem_off[0] = 0;
        mem_w[1] = 32'h02800113; mem_br[1] = 0; mem_off[1] = 0;
        mem_w[2] = 32'h00A08093; mem_br[2] = 0; mem_off[2] = 0;
        mem_w[3] = 32'hFE209EE3; mem_br[3] = 1; mem_off[3] = -4;
        for (int i = 4; i < 16; i++) begin
            int r;
            r = int'($urandom_range(0, 3));
            mem_off[i] = 0;
            mem_br[i]  = 0;
            if (r < 2) begin
                mem_off[i] = (int'($urandom_range(0, 16)) - 8) * 4;
                mem_w[i]   = enc_br(mem_off[i]);
                mem_br[i]  = 1;
            end else if (r == 2) begin
                mem_w[i] = {$urandom_range(0, 33554431), 7'b1101111};
            end else begin
                mem_w[i] = {$urandom_range(0, 33554431), 7'b0010011};
            end
        end
        model_reset();

        // T1 reset and straight-line fetch
        repeat (2) @(negedge clk_i);
        check_all("t1_rst");
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) step("t1");
        chk("t1_pc10", pc_o, 32'h10);
        chk("t1_ifpcC", if_pc_o, 32'hC);
        chk("t2_cold", {31'd0, if_pred_o}, 32'd0);

        // T2 redirect
        ex_redirect_i = 1; ex_target_i = 32'h8;
        step("t2_redir");
        chk("t2_pc8", pc_o, 32'h8);
        idle();
        step("t2");

        // T3 train taken twice while stalled, then fetch 0xC
        stall_i = 1; ex_update_i = 1; ex_pc_i = 32'hC; ex_taken_i = 1;
        repeat (2) step("t3_train");
        idle();
        step("t3_fetch");
        chk("t3_pc8", pc_o, 32'h8);
        chk("t3_pred", {31'd0, if_pred_o}, 32'd1);

        // T4 saturation both ways
        stall_i = 1; ex_update_i = 1; ex_pc_i = 32'hC; ex_taken_i = 1;
        step("t4_sat_hi");
        ex_taken_i = 0;
        repeat (4) step("t4_down");
        idle();
        step("t4");
        step("t4_fetch");
        chk("t4_pc10", pc_o, 32'h10);
        chk("t4_pred", {31'd0, if_pred_o}, 32'd0);

        // T5 stall holds, redirect overrides stall
        stall_i = 1;
        repeat (3) step("t5_stall");
        ex_redirect_i = 1; ex_target_i = 32'h20;
        step("t5_redir");
        chk("t5_pc20", pc_o, 32'h20);
        chk("t5_valid", {31'd0, if_valid_o}, 32'd0);
        idle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            stall_i       = ($urandom_range(0, 4) == 0);
            ex_redirect_i = ($urandom_range(0, 9) == 0);
            ex_target_i   = ($urandom_range(0, 7) == 0) ?
                            ($urandom & 32'hFFFF_FFFC) :
                            32'($urandom_range(0, 15)) << 2;
            ex_update_i   = ($urandom_range(0, 2) == 0);
            ex_pc_i       = 32'($urandom_range(0, 15)) << 2;
            ex_taken_i    = $urandom_range(0, 1) == 1;
            step("rnd");
        end
        idle();

        // T6 reset mid-run: train 0xC to 11, pulse reset off-edge
        stall_i = 1; ex_update_i = 1; ex_pc_i = 32'hC; ex_taken_i = 1;
        repeat (3) step("t6_train");
        stall_i = 0;
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(posedge clk_i);
        @(negedge clk_i);
        idle();
        rst_ni = 1'b1;
        ex_redirect_i = 0;
        for (int i = 0; i < 4; i++) step("t6_run");
        chk("t6_pc10", pc_o, 32'h10);
        chk("t6_cold", {31'd0, if_pred_o}, 32'd0);

        for (int k = 0; k < 200; k++) begin
            stall_i       = ($urandom_range(0, 3) == 0);
            ex_redirect_i = ($urandom_range(0, 7) == 0);
            ex_target_i   = 32'($urandom_range(0, 15)) << 2;
            ex_update_i   = ($urandom_range(0, 1) == 0);
            ex_pc_i       = 32'($urandom_range(0, 15)) << 2;
            ex_taken_i    = $urandom_range(0, 1) == 1;
            step("rnd2");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
